// File: rtl/usb_bit_rx_pkg.sv
// Shared definitions for the full-speed USB receive front end.
// Covers line-state encodings, receiver FSM states and bit-stuffing limits.
`timescale 1ns/1ps
package usb_bit_rx_pkg;

  // Encoded as {D+, D-} after synchronisation
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_K   = 2'b01,
    LS_J   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_ABORT,
    ST_EOP
  } rx_state_t;

  localparam int MAX_ONES        = 6;
  localparam int ABORT_IDLE_BITS = 8;

endpackage

// File: rtl/usb_rx_dpll.sv
// Pad synchroniser, line-state decode and oversampling phase counter.
// Produces one sample strobe per bit, re-centred on every line-state change.
`timescale 1ns/1ps
module usb_rx_dpll
  import usb_bit_rx_pkg::*;
#(
  parameter int CLK_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        usb_dp,
  input  logic        usb_dn,
  output line_state_t line_state,
  output logic        sample_stb
);

  localparam int PW = $clog2(CLK_PER_BIT);
  localparam logic [PW-1:0] PH_LAST   = PW'(CLK_PER_BIT - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(CLK_PER_BIT / 2 - 1);

  // Bit 0 is the metastability flop, bit 1 the usable synced value
  logic [1:0]    dp_sync_reg;
  logic [1:0]    dn_sync_reg;
  line_state_t   ls_prev_reg;
  logic [PW-1:0] phase_reg;
  logic [PW-1:0] phase_cur;

  // Synchroniser resets to J so the bus looks idle, not SE0, right after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_sync_reg <= 2'b11;
      dn_sync_reg <= 2'b00;
      ls_prev_reg <= LS_J;
      phase_reg   <= '0;
    end else begin
      dp_sync_reg <= {dp_sync_reg[0], usb_dp};
      dn_sync_reg <= {dn_sync_reg[0], usb_dn};
      ls_prev_reg <= line_state;
      phase_reg   <= (phase_cur == PH_LAST) ? '0 : phase_cur + 1'b1;
    end
  end

  always_comb begin
    line_state = LS_J;
    case ({dp_sync_reg[1], dn_sync_reg[1]})
      2'b00:   line_state = LS_SE0;
      2'b01:   line_state = LS_K;
      default: line_state = LS_J;
    endcase
  end

  assign phase_cur  = (line_state != ls_prev_reg) ? '0 : phase_reg;
  assign sample_stb = (phase_cur == PH_SAMPLE);

endmodule

// File: rtl/usb_bit_rx.sv
// Full-speed USB receive front end: SYNC detection, NRZI decode, bit destuffing,
// EOP/abort handling and bus-reset timing on top of the oversampling DPLL.
`timescale 1ns/1ps
module usb_bit_rx
  import usb_bit_rx_pkg::*;
#(
  parameter int CLK_PER_BIT      = 4,
  parameter int SYNC_MIN_TOGGLES = 3,
  parameter int RESET_CLKS       = 120
) (
  input  logic clk,
  input  logic rst_n,
  input  logic usb_dp,
  input  logic usb_dn,
  output logic rx_start,
  output logic rx_status,
  output logic rx_bit,
  output logic rx_finish,
  output logic rx_stuff_err,
  output logic rx_active,
  output logic usb_bus_reset
);

  localparam int TW = $clog2(SYNC_MIN_TOGGLES + 1);
  localparam int CW = $clog2(RESET_CLKS + 1);
  localparam logic [TW-1:0] TOG_SAT   = TW'(SYNC_MIN_TOGGLES);
  localparam logic [CW-1:0] SE0_SAT   = CW'(RESET_CLKS);
  localparam logic [2:0]    ONES_LIM  = 3'(MAX_ONES);
  localparam logic [2:0]    JCNT_LAST = 3'(ABORT_IDLE_BITS - 1);

  line_state_t line_state;
  logic        sample_stb;

  usb_rx_dpll #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_dpll (
    .clk       (clk),
    .rst_n     (rst_n),
    .usb_dp    (usb_dp),
    .usb_dn    (usb_dn),
    .line_state(line_state),
    .sample_stb(sample_stb)
  );

  rx_state_t     state_reg, state_next;
  line_state_t   prev_reg, prev_next;
  logic [TW-1:0] tog_reg, tog_next;
  logic [2:0]    ones_reg, ones_next;
  logic [2:0]    jcnt_reg, jcnt_next;
  logic [CW-1:0] se0_cnt_reg, se0_cnt_next;
  logic          start_reg, start_next;
  logic          status_reg, status_next;
  logic          bit_reg, bit_next;
  logic          finish_reg, finish_next;
  logic          err_reg, err_next;
  logic          active_reg, active_next;
  logic          bus_reset;
  logic          nrzi_one;

  assign bus_reset = (se0_cnt_reg == SE0_SAT);
  assign nrzi_one  = (line_state == prev_reg);

  // SE0 timer runs every clk, independent of bit sampling
  always_comb begin
    se0_cnt_next = '0;
    if (line_state == LS_SE0)
      se0_cnt_next = bus_reset ? se0_cnt_reg : se0_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      prev_reg    <= LS_J;
      tog_reg     <= '0;
      ones_reg    <= '0;
      jcnt_reg    <= '0;
      se0_cnt_reg <= '0;
      start_reg   <= 1'b0;
      status_reg  <= 1'b0;
      bit_reg     <= 1'b0;
      finish_reg  <= 1'b0;
      err_reg     <= 1'b0;
      active_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      prev_reg    <= prev_next;
      tog_reg     <= tog_next;
      ones_reg    <= ones_next;
      jcnt_reg    <= jcnt_next;
      se0_cnt_reg <= se0_cnt_next;
      start_reg   <= start_next;
      status_reg  <= status_next;
      bit_reg     <= bit_next;
      finish_reg  <= finish_next;
      err_reg     <= err_next;
      active_reg  <= active_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    prev_next   = prev_reg;
    tog_next    = tog_reg;
    ones_next   = ones_reg;
    jcnt_next   = jcnt_reg;
    start_next  = 1'b0;
    status_next = 1'b0;
    bit_next    = 1'b0;
    finish_next = 1'b0;
    err_next    = 1'b0;
    active_next = active_reg;

    if (bus_reset) begin
      // Bus reset overrides everything; a packet in flight is closed once
      state_next  = ST_IDLE;
      ones_next   = '0;
      finish_next = active_reg;
      active_next = 1'b0;
    end else if (sample_stb) begin
      prev_next = line_state;
      case (state_reg)
        ST_IDLE: begin
          if (line_state == LS_K) begin
            state_next = ST_SYNC;
            tog_next   = TW'(1);
          end
        end
        ST_SYNC: begin
          if (line_state == LS_SE0) begin
            state_next = ST_IDLE;
          end else if (line_state != prev_reg) begin
            if (tog_reg != TOG_SAT)
              tog_next = tog_reg + 1'b1;
          end else if (line_state == LS_K && tog_reg >= TOG_SAT) begin
            // Closing KK is itself a decoded 1 that counts toward stuffing
            state_next  = ST_DATA;
            start_next  = 1'b1;
            active_next = 1'b1;
            ones_next   = 3'd1;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (line_state == LS_SE0) begin
            state_next = ST_EOP;
          end else if (ones_reg == ONES_LIM) begin
            if (nrzi_one) begin
              err_next   = 1'b1;
              state_next = ST_ABORT;
              jcnt_next  = '0;
            end else begin
              ones_next = '0;
            end
          end else begin
            status_next = 1'b1;
            bit_next    = nrzi_one;
            ones_next   = nrzi_one ? ones_reg + 1'b1 : 3'd0;
          end
        end
        ST_ABORT: begin
          if (line_state == LS_SE0) begin
            state_next = ST_EOP;
          end else if (line_state == LS_J) begin
            if (jcnt_reg == JCNT_LAST) begin
              finish_next = 1'b1;
              active_next = 1'b0;
              state_next  = ST_IDLE;
              jcnt_next   = '0;
            end else begin
              jcnt_next = jcnt_reg + 1'b1;
            end
          end else begin
            jcnt_next = '0;
          end
        end
        ST_EOP: begin
          // K here is a malformed EOP; close anyway and let CRC reject it
          if (line_state != LS_SE0) begin
            finish_next = 1'b1;
            active_next = 1'b0;
            state_next  = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign rx_start      = start_reg;
  assign rx_status     = status_reg;
  assign rx_bit        = bit_reg;
  assign rx_finish     = finish_reg;
  assign rx_stuff_err  = err_reg;
  assign rx_active     = active_reg;
  assign usb_bus_reset = bus_reset;

endmodule

// File: tb/tb_usb_bit_rx.sv
// Directed bench for usb_bit_rx: NRZI/stuffing encoder drives the pads,
// an event monitor logs receiver pulses, and per-test deltas are checked.
`timescale 1ns/1ps
module tb_usb_bit_rx;

  localparam int CPB = 4;
  localparam logic [1:0] SJ   = 2'b10;
  localparam logic [1:0] SK   = 2'b01;
  localparam logic [1:0] SSE0 = 2'b00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic usb_dp = 1'b1;
  logic usb_dn = 1'b0;
  logic rx_start, rx_status, rx_bit, rx_finish, rx_stuff_err, rx_active, usb_bus_reset;

  usb_bit_rx #(
    .CLK_PER_BIT     (CPB),
    .SYNC_MIN_TOGGLES(3),
    .RESET_CLKS      (120)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .usb_dp       (usb_dp),
    .usb_dn       (usb_dn),
    .rx_start     (rx_start),
    .rx_status    (rx_status),
    .rx_bit       (rx_bit),
    .rx_finish    (rx_finish),
    .rx_stuff_err (rx_stuff_err),
    .rx_active    (rx_active),
    .usb_bus_reset(usb_bus_reset)
  );

  always #5 clk = ~clk;

  // Monitor: cumulative event counts, written only here
  int   n_start, n_status, n_finish, n_err, n_busrst, n_excl;
  logic bit_log [0:1023];

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_start) n_start <= n_start + 1;
      if (rx_status) begin
        bit_log[n_status] <= rx_bit;
        n_status <= n_status + 1;
      end
      if (rx_finish) n_finish <= n_finish + 1;
      if (rx_stuff_err) n_err <= n_err + 1;
      if (usb_bus_reset) n_busrst <= n_busrst + 1;
      if (int'(rx_start) + int'(rx_status) + int'(rx_finish) > 1) n_excl <= n_excl + 1;
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  int b_start, b_status, b_finish, b_err, b_busrst;

  task automatic snap();
    b_start  = n_start;
    b_status = n_status;
    b_finish = n_finish;
    b_err    = n_err;
    b_busrst = n_busrst;
  endtask

  function automatic logic [63:0] got_bits(input int base, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = bit_log[base + i];
    return v;
  endfunction

  // Symbol-level encoder
  logic [1:0] sym_q[$];
  logic [1:0] lvl;
  int         ones;
  int         jit_i = 0;

  task automatic hold(input logic [1:0] ls, input int cyc);
    {usb_dp, usb_dn} = ls;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic add_sync();
    sym_q.push_back(SK); sym_q.push_back(SJ); sym_q.push_back(SK); sym_q.push_back(SJ);
    sym_q.push_back(SK); sym_q.push_back(SJ); sym_q.push_back(SK); sym_q.push_back(SK);
    lvl  = SK;
    ones = 1;
  endtask

  task automatic add_bits(input logic [63:0] data, input int n, input bit stuff);
    for (int i = 0; i < n; i++) begin
      if (data[i]) begin
        ones++;
      end else begin
        lvl  = (lvl == SJ) ? SK : SJ;
        ones = 0;
      end
      sym_q.push_back(lvl);
      if (stuff && ones == 6) begin
        lvl  = (lvl == SJ) ? SK : SJ;
        ones = 0;
        sym_q.push_back(lvl);
      end
    end
  endtask

  task automatic add_eop();
    sym_q.push_back(SSE0); sym_q.push_back(SSE0); sym_q.push_back(SJ);
  endtask

  // Runs of equal symbols become one segment; jitter moves each edge by -1/0/+1 clk
  task automatic emit(input bit jit);
    int i = 0;
    while (i < sym_q.size()) begin
      int m = 1;
      int d = 0;
      while (i + m < sym_q.size() && sym_q[i + m] == sym_q[i]) m++;
      if (jit) begin
        d = (jit_i % 3) - 1;
        jit_i++;
      end
      hold(sym_q[i], CPB * m + d);
      i += m;
    end
    sym_q.delete();
  endtask

  initial begin
    hold(SJ, 5);
    check("rst_outputs", {57'd0, rx_start, rx_status, rx_bit, rx_finish, rx_stuff_err, rx_active, usb_bus_reset}, 64'd0);
    rst_n = 1'b1;
    hold(SJ, 20);
    check("idle_outputs", {57'd0, rx_start, rx_status, rx_bit, rx_finish, rx_stuff_err, rx_active, usb_bus_reset}, 64'd0);

    // 1: IN PID
    snap(); add_sync(); add_bits(64'h69, 8, 1); add_eop(); emit(0); hold(SJ, 40);
    check("t1_start", 64'(n_start - b_start), 64'd1);
    check("t1_nstatus", 64'(n_status - b_status), 64'd8);
    check("t1_bits", got_bits(b_status, 8), 64'h69);
    check("t1_finish", 64'(n_finish - b_finish), 64'd1);
    check("t1_active", {63'd0, rx_active}, 64'd0);
    $display("t1 pid 0x69: start=%0d status=%0d finish=%0d", n_start - b_start, n_status - b_status, n_finish - b_finish);

    // 2: 0xFF then 0x00 with stuffed zero
    snap(); add_sync(); add_bits(64'h00FF, 16, 1); add_eop(); emit(0); hold(SJ, 40);
    check("t2_nstatus", 64'(n_status - b_status), 64'd16);
    check("t2_bits", got_bits(b_status, 16), 64'h00FF);
    check("t2_finish", 64'(n_finish - b_finish), 64'd1);
    $display("t2 stuffed 0xFF,0x00: status=%0d", n_status - b_status);

    // 3: seven 1s including SYNC's last -> stuff error
    snap(); add_sync(); add_bits(64'h3F, 6, 0); add_eop(); emit(0); hold(SJ, 40);
    check("t3_nstatus", 64'(n_status - b_status), 64'd5);
    check("t3_bits", got_bits(b_status, 5), 64'h1F);
    check("t3_stuff_err", 64'(n_err - b_err), 64'd1);
    check("t3_finish", 64'(n_finish - b_finish), 64'd1);
    $display("t3 stuff error: status=%0d err=%0d", n_status - b_status, n_err - b_err);

    // 4: 64-bit jittered packet
    snap(); add_sync(); add_bits(64'h3C96_7E81_A5C3_0FF0, 64, 1); add_eop(); emit(1); hold(SJ, 40);
    check("t4_nstatus", 64'(n_status - b_status), 64'd64);
    check("t4_bits", got_bits(b_status, 64), 64'h3C96_7E81_A5C3_0FF0);
    check("t4_finish", 64'(n_finish - b_finish), 64'd1);
    $display("t4 jittered 64 bits: status=%0d", n_status - b_status);

    // 5: short SYNC rejected
    snap(); sym_q.push_back(SK); sym_q.push_back(SK); emit(0); hold(SJ, 60);
    check("t5_no_start", 64'(n_start - b_start), 64'd0);
    check("t5_no_finish", 64'(n_finish - b_finish), 64'd0);
    check("t5_inactive", {63'd0, rx_active}, 64'd0);
    $display("t5 short sync: start=%0d", n_start - b_start);

    // 6: long SE0 mid-packet -> bus reset
    snap(); add_sync(); add_bits(64'hC3, 8, 1); emit(0);
    hold(SSE0, 130);
    hold(SJ, 40);
    check("t6_finish", 64'(n_finish - b_finish), 64'd1);
    check("t6_busrst_cycles", 64'(n_busrst - b_busrst), 64'd11);
    check("t6_busrst_clear", {63'd0, usb_bus_reset}, 64'd0);
    check("t6_bits", got_bits(b_status, 8), 64'hC3);
    $display("t6 bus reset: finish=%0d busrst_cycles=%0d", n_finish - b_finish, n_busrst - b_busrst);

    // 7: async reset mid-DATA, then a clean packet
    snap(); add_sync(); add_bits(64'hA5, 8, 1); emit(0);
    check("t7_active_pre", {63'd0, rx_active}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_outputs", {57'd0, rx_start, rx_status, rx_bit, rx_finish, rx_stuff_err, rx_active, usb_bus_reset}, 64'd0);
    {usb_dp, usb_dn} = SJ;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    hold(SJ, 20);
    check("t7_no_finish", 64'(n_finish - b_finish), 64'd0);
    snap(); add_sync(); add_bits(64'h69, 8, 1); add_eop(); emit(0); hold(SJ, 40);
    check("t7_start", 64'(n_start - b_start), 64'd1);
    check("t7_bits", got_bits(b_status, 8), 64'h69);
    check("t7_finish", 64'(n_finish - b_finish), 64'd1);
    $display("t7 reset recovery: start=%0d status=%0d", n_start - b_start, n_status - b_status);

    check("exclusive_pulses", 64'(n_excl), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
